// File: rtl/mul_booth_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mul_booth_pipe
// Purpose  : Three-stage pipelined radix-4 Booth / Wallace-tree multiplier.
//            It has a per-beat signed/unsigned mode, valid/ready handshakes
//            on both sides and a sideband tag that travels with each op.
//            S1 holds the Booth partial products.
//            S2 holds the Wallace-tree sum/carry rows.
//            S3 holds the final product, which drives the out_* ports.
// Ports    : clk, rst          clock, synchronous active-high reset
//            in_valid/in_ready operand handshake
//            in_a, in_b        multiplicand / multiplier (WIDTH bits)
//            in_signed         1: two's complement operands, 0: unsigned
//            in_tag            sideband tag (TAG_W bits)
//            out_valid/out_ready product handshake
//            out_prod          exact product (2*WIDTH bits)
//            out_tag           tag of the op that produced out_prod
// Revision : 1.0 - initial release
// ============================================================================
module mul_booth_pipe #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int PW  = 2 * WIDTH;     // product width
   localparam int XW  = WIDTH + 2;     // extended operand width
   localparam int NPP = WIDTH / 2 + 1; // number of Booth partial products

   // Number of rows left after each 3:2 reduction level, starting from NPP.
   function automatic int rows_at(input int lvl);
      int n;
      n = NPP;
      for (int k = 0; k < lvl; k++) begin
         n = 2 * (n / 3) + (n % 3);
      end
      return n;
   endfunction

   function automatic int num_levels();
      int n;
      int lv;
      n  = NPP;
      lv = 0;
      while (n > 2) begin
         n  = 2 * (n / 3) + (n % 3);
         lv = lv + 1;
      end
      return lv;
   endfunction

   localparam int NLVL = num_levels();

   // ------------------------------------------------------------------
   // Stage handshake chain: a stage can take new data when it is empty
   // or when its own contents leave this cycle.
   // ------------------------------------------------------------------
   logic v1_q, v2_q, v3_q;
   logic w_en1, w_en2, w_en3;
   logic w_ld1, w_ld2, w_ld3;

   assign w_en3 = !v3_q || out_ready;
   assign w_ld3 = v2_q && w_en3;
   assign w_en2 = !v2_q || w_ld3;
   assign w_ld2 = v1_q && w_en2;
   assign w_en1 = !v1_q || w_ld2;
   assign w_ld1 = in_valid && w_en1;

   assign in_ready = w_en1;

   // ------------------------------------------------------------------
   // Booth radix-4 recoding. The operands are extended to XW bits, so
   // one recoding handles both modes. The mode is folded into the
   // partial products and is not needed downstream.
   // ------------------------------------------------------------------
   logic [XW-1:0] w_ax;
   logic [XW-1:0] w_bx;
   logic [XW:0]   w_bz;    // multiplier with the implicit zero below bit 0
   logic [PW-1:0] w_ax_pw;
   logic [PW-1:0] w_pp [NPP];

   assign w_ax    = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
   assign w_bx    = {{2{in_signed & in_b[WIDTH-1]}}, in_b};
   assign w_bz    = {w_bx, 1'b0};
   assign w_ax_pw = {{(PW-XW){w_ax[XW-1]}}, w_ax};

   generate
      for (genvar i = 0; i < NPP; i++) begin : g_booth
         logic [2:0]    w_trip;
         logic [PW-1:0] w_mag;
         logic [PW-1:0] w_sgn;
         logic          w_neg;

         assign w_trip = w_bz[2*i+2 : 2*i];
         // 100/101/110 select a negative digit; 111 is zero, not -0.
         assign w_neg  = w_trip[2] & ~(w_trip[1] & w_trip[0]);

         always_comb begin
            w_mag = '0;
            case (w_trip)
               3'b001, 3'b010, 3'b101, 3'b110: w_mag = w_ax_pw;
               3'b011, 3'b100:                 w_mag = w_ax_pw << 1;
               default:                        w_mag = '0;
            endcase
         end

         assign w_sgn    = w_neg ? (~w_mag + 1'b1) : w_mag;
         assign w_pp[i]  = w_sgn << (2 * i);
      end
   endgenerate

   // ------------------------------------------------------------------
   // Stage S1 registers
   // ------------------------------------------------------------------
   logic [PW-1:0]    pp_q [NPP];
   logic [TAG_W-1:0] tag1_q;

   always_ff @(posedge clk) begin
      if (w_ld1) begin
         pp_q   <= w_pp;
         tag1_q <= in_tag;
      end
   end

   // ------------------------------------------------------------------
   // Wallace tree: each level compresses every full group of three rows
   // into a sum row and a carry row. Leftover rows pass straight through.
   // Two spare columns keep the constant-index loop bounds in range.
   // ------------------------------------------------------------------
   logic [PW-1:0] w_t [NLVL+1][NPP+2];

   always_comb begin
      for (int l = 0; l <= NLVL; l++) begin
         for (int r = 0; r < NPP + 2; r++) begin
            w_t[l][r] = '0;
         end
      end
      for (int r = 0; r < NPP; r++) begin
         w_t[0][r] = pp_q[r];
      end
      for (int l = 0; l < NLVL; l++) begin
         for (int g = 0; g < NPP / 3; g++) begin
            if (g < rows_at(l) / 3) begin
               w_t[l+1][2*g]   = w_t[l][3*g] ^ w_t[l][3*g+1] ^ w_t[l][3*g+2];
               w_t[l+1][2*g+1] = ((w_t[l][3*g]   & w_t[l][3*g+1]) |
                                  (w_t[l][3*g]   & w_t[l][3*g+2]) |
                                  (w_t[l][3*g+1] & w_t[l][3*g+2])) << 1;
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (r < rows_at(l) % 3) begin
               w_t[l+1][2*(rows_at(l)/3)+r] = w_t[l][3*(rows_at(l)/3)+r];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage S2 registers
   // ------------------------------------------------------------------
   logic [PW-1:0]    sum_q,   sum_d;
   logic [PW-1:0]    carry_q, carry_d;
   logic [TAG_W-1:0] tag2_q;

   assign sum_d   = w_t[NLVL][0];
   assign carry_d = w_t[NLVL][1];

   always_ff @(posedge clk) begin
      if (w_ld2) begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         tag2_q  <= tag1_q;
      end
   end

   // ------------------------------------------------------------------
   // Stage S3 registers, valid bits and the output product
   // ------------------------------------------------------------------
   logic [PW-1:0]    prod_q, prod_d;
   logic [TAG_W-1:0] tag3_q;
   logic             v1_d, v2_d, v3_d;

   assign prod_d = sum_q + carry_q;
   assign v1_d   = w_en1 ? in_valid : v1_q;
   assign v2_d   = w_en2 ? v1_q     : v2_q;
   assign v3_d   = w_en3 ? v2_q     : v3_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         v3_q   <= 1'b0;
         prod_q <= '0;
         tag3_q <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         if (w_ld3) begin
            prod_q <= prod_d;
            tag3_q <= tag2_q;
         end
      end
   end

   assign out_valid = v3_q;
   assign out_prod  = prod_q;
   assign out_tag   = tag3_q;

endmodule
`default_nettype wire
